// File: rtl/gray_convert_pkg.sv
// Shared types and constants for the RGB-to-grayscale conversion stage.
package gray_convert_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bus widths
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CH_W   = 8;
    localparam int unsigned SUM_W  = 16;
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned WE_W   = 4;

    // Luma weights (BT.601 scaled by 256) and round-half-up constant
    localparam int unsigned COEF_R  = 77;
    localparam int unsigned COEF_G  = 150;
    localparam int unsigned COEF_B  = 29;
    localparam int unsigned ROUND_C = 128;

    // Edges from source address register to destination write
    localparam int unsigned PIPE_DEPTH = 3;

    localparam logic [WE_W-1:0] WE_ALL  = 4'b1111;
    localparam logic [WE_W-1:0] WE_NONE = 4'b0000;

    // Source BRAM word layout; the top byte carries no colour information
    typedef struct packed {
        logic [CH_W-1:0] pad;
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_word_t;

    // Word-aligned byte address of pixel index p
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] p);
        return p << 2;
    endfunction

endpackage

// File: rtl/gray_convert_mac.sv
// Two-stage weighted sum of three 8-bit channels with round and saturate.
// Stage 1 registers the three products, stage 2 registers the saturated
// result. The result is forced to zero on cycles without a valid pixel so
// downstream write data is clean when nothing is being written.
module gray_mac
    import gray_convert_pkg::*;
#(
    parameter int unsigned C_R   = COEF_R,
    parameter int unsigned C_G   = COEF_G,
    parameter int unsigned C_B   = COEF_B,
    parameter int unsigned RND   = ROUND_C
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    input  logic [CH_W-1:0] i_r,
    input  logic [CH_W-1:0] i_g,
    input  logic [CH_W-1:0] i_b,
    output logic            o_valid,
    output logic [CH_W-1:0] o_gray
);

    localparam logic [CH_W-1:0]  CH_MAX = '1;
    localparam logic [SUM_W-1:0] SAT_LIM = SUM_W'(CH_MAX);

    logic             r_v1;
    logic [SUM_W-1:0] r_pr;
    logic [SUM_W-1:0] r_pg;
    logic [SUM_W-1:0] r_pb;
    logic             r_v2;
    logic [CH_W-1:0]  r_gray;

    logic [SUM_W-1:0] w_prod_r;
    logic [SUM_W-1:0] w_prod_g;
    logic [SUM_W-1:0] w_prod_b;
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_shift;
    logic [CH_W-1:0]  w_sat;

    assign w_prod_r = SUM_W'(C_R) * SUM_W'(i_r);
    assign w_prod_g = SUM_W'(C_G) * SUM_W'(i_g);
    assign w_prod_b = SUM_W'(C_B) * SUM_W'(i_b);

    assign w_sum   = r_pr + r_pg + r_pb + SUM_W'(RND);
    assign w_shift = w_sum >> FRAC_W;
    assign w_sat   = (w_shift > SAT_LIM) ? CH_MAX : w_shift[CH_W-1:0];

    // Stage 1: register per-channel products alongside the valid bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_pr <= '0;
            r_pg <= '0;
            r_pb <= '0;
        end else begin
            r_v1 <= i_valid;
            r_pr <= i_valid ? w_prod_r : '0;
            r_pg <= i_valid ? w_prod_g : '0;
            r_pb <= i_valid ? w_prod_b : '0;
        end
    end

    // Stage 2: register the rounded, saturated sum
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_gray <= '0;
        end else begin
            r_v2   <= r_v1;
            r_gray <= r_v1 ? w_sat : '0;
        end
    end

    assign o_valid = r_v2;
    assign o_gray  = r_gray;

endmodule

// File: rtl/gray_convert.sv
// Streams one RGB frame from a source BRAM through a luma MAC into a
// grayscale BRAM, one pixel per clock, then reports completion on done.
module gray_convert
    import gray_convert_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 256,
    parameter int unsigned IMG_HEIGHT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_dout,
    output logic              src_en,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_din,
    output logic [WE_W-1:0]   dst_we
);

    localparam int unsigned     N_PIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned     P_W    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam logic [P_W-1:0]  P_LAST = P_W'(N_PIX - 1);
    localparam int unsigned     DR_W   = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(PIPE_DEPTH - 1);

    // Sequencer state and registered outputs
    state_t             r_state;
    logic [P_W-1:0]     r_p;
    logic [DR_W-1:0]    r_drain;
    logic               r_done;
    logic               r_src_en;
    logic [ADDR_W-1:0]  r_src_addr;

    // Pixel-index tags that travel with the valid bits
    logic               r_v1;
    logic [P_W-1:0]     r_idx1;
    logic               r_v2;
    logic [P_W-1:0]     r_idx2;
    logic [ADDR_W-1:0]  r_dst_addr;

    logic [P_W-1:0]     w_p_next;
    rgb_word_t          w_px;
    logic               w_mac_valid;
    logic [CH_W-1:0]    w_gray;
    logic               w_unused_pad;

    assign w_p_next     = r_p + P_W'(1);
    assign w_px         = rgb_word_t'(src_dout);
    assign w_unused_pad = &{1'b0, w_px.pad};

    // Frame sequencer: issues one source read per RUN cycle, then drains
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_p        <= '0;
            r_drain    <= '0;
            r_done     <= 1'b0;
            r_src_en   <= 1'b0;
            r_src_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_RUN;
                        r_p        <= '0;
                        r_src_en   <= 1'b1;
                        r_src_addr <= '0;
                    end
                end
                ST_RUN: begin
                    if (r_p == P_LAST) begin
                        r_state    <= ST_DRAIN;
                        r_p        <= '0;
                        r_drain    <= '0;
                        r_src_en   <= 1'b0;
                        r_src_addr <= '0;
                    end else begin
                        r_p        <= w_p_next;
                        r_src_addr <= pix_addr(ADDR_W'(w_p_next));
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DR_LAST) begin
                        r_state <= ST_DONE;
                        r_drain <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + DR_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_p        <= '0;
                    r_drain    <= '0;
                    r_done     <= 1'b0;
                    r_src_en   <= 1'b0;
                    r_src_addr <= '0;
                end
            endcase
        end
    end

    // Carry the pixel index beside the BRAM read and the MAC stages
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1       <= 1'b0;
            r_idx1     <= '0;
            r_v2       <= 1'b0;
            r_idx2     <= '0;
            r_dst_addr <= '0;
        end else begin
            r_v1   <= r_src_en;
            r_idx1 <= r_p;
            r_v2   <= r_v1;
            r_idx2 <= r_idx1;
            if (r_v2) begin
                r_dst_addr <= pix_addr(ADDR_W'(r_idx2));
            end
        end
    end

    gray_mac u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_v1),
        .i_r     (w_px.r),
        .i_g     (w_px.g),
        .i_b     (w_px.b),
        .o_valid (w_mac_valid),
        .o_gray  (w_gray)
    );

    assign done     = r_done;
    assign src_en   = r_src_en;
    assign src_addr = r_src_addr;
    assign dst_addr = r_dst_addr;
    assign dst_din  = DATA_W'(w_gray);
    assign dst_we   = w_mac_valid ? WE_ALL : WE_NONE;

endmodule

// File: tb/tb_gray_convert.sv
// Directed bench for gray_convert on a 4x4 frame with a behavioural BRAM.
module tb_gray_convert;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        done;
    logic [31:0] src_addr;
    logic [31:0] src_dout;
    logic        src_en;
    logic [31:0] dst_addr;
    logic [31:0] dst_din;
    logic [3:0]  dst_we;

    logic [31:0] mem [16];
    logic [7:0]  exp_gray [16];

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int bad_cnt = 0;

    gray_convert #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .done     (done),
        .src_addr (src_addr),
        .src_dout (src_dout),
        .src_en   (src_en),
        .dst_addr (dst_addr),
        .dst_din  (dst_din),
        .dst_we   (dst_we)
    );

    always #5 clk = ~clk;

    // Source BRAM with one-cycle read latency
    always @(posedge clk) begin
        if (src_en) src_dout <= mem[src_addr[5:2]];
    end

    // Count destination writes and any that fall outside the frame
    always @(posedge clk) begin
        if (dst_we == 4'b1111) begin
            wr_cnt++;
            if (dst_addr >= 32'd64) bad_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_ramp();
        for (int p = 0; p < 16; p++) begin
            mem[p]      = {8'h00, 8'(p), 8'(p), 8'(p)};
            exp_gray[p] = 8'(p);
        end
    endtask

    // One full frame with start held high; c counts samples after the start edge
    task automatic run_frame(input logic [31:0] hold_addr);
        int   w0;
        logic wr;
        w0    = wr_cnt;
        start = 1'b1;
        step();
        for (int c = 0; c < 25; c++) begin
            wr = (c >= 3) && (c <= 18);
            check("src_en",   32'(src_en),   (c <= 15) ? 32'd1 : 32'd0);
            check("src_addr", src_addr,      (c <= 15) ? 32'(4 * c) : 32'd0);
            check("dst_we",   32'(dst_we),   wr ? 32'hF : 32'h0);
            check("dst_din",  dst_din,       wr ? 32'(exp_gray[c - 3]) : 32'd0);
            check("dst_addr", dst_addr,      wr ? 32'(4 * (c - 3)) : ((c < 3) ? hold_addr : 32'd60));
            check("done",     32'(done),     (c >= 19) ? 32'd1 : 32'd0);
            if (c < 24) step();
        end
        check("frame_writes", 32'(wr_cnt - w0), 32'd16);
        check("addr_range",   32'(bad_cnt),     32'd0);
    endtask

    initial begin
        int w0;
        rst_n    = 1'b0;
        start    = 1'b0;
        src_dout = 32'd0;
        load_ramp();

        // Reset state
        repeat (3) step();
        check("rst_done",     32'(done),   32'd0);
        check("rst_src_en",   32'(src_en), 32'd0);
        check("rst_src_addr", src_addr,    32'd0);
        check("rst_dst_addr", dst_addr,    32'd0);
        check("rst_dst_din",  dst_din,     32'd0);
        check("rst_dst_we",   32'(dst_we), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_src_en", 32'(src_en), 32'd0);

        // Ramp frame, then drop start and confirm return to IDLE
        run_frame(32'd0);
        start = 1'b0;
        step();
        check("done_drop",   32'(done),   32'd0);
        check("idle_src_en", 32'(src_en), 32'd0);
        step();
        check("idle_hold",   32'(src_en), 32'd0);

        // Second frame must repeat the first
        run_frame(32'd60);
        start = 1'b0;
        step();
        step();

        // Colour corner cases, including a non-zero pad byte
        mem[0] = 32'h00FFFFFF; exp_gray[0] = 8'd255;
        mem[1] = 32'h00FF0000; exp_gray[1] = 8'd77;
        mem[2] = 32'h0000FF00; exp_gray[2] = 8'd149;
        mem[3] = 32'h000000FF; exp_gray[3] = 8'd29;
        mem[4] = 32'h00000000; exp_gray[4] = 8'd0;
        mem[5] = 32'hFF0A141E; exp_gray[5] = 8'd18;
        run_frame(32'd60);
        start = 1'b0;
        step();
        step();

        // Reset while reading pixel 7
        load_ramp();
        start = 1'b1;
        step();
        repeat (7) step();
        check("mid_src_addr", src_addr, 32'd28);
        rst_n = 1'b0;
        start = 1'b0;
        step();
        check("mrst_done",     32'(done),   32'd0);
        check("mrst_src_en",   32'(src_en), 32'd0);
        check("mrst_src_addr", src_addr,    32'd0);
        check("mrst_dst_addr", dst_addr,    32'd0);
        check("mrst_dst_din",  dst_din,     32'd0);
        check("mrst_dst_we",   32'(dst_we), 32'd0);
        rst_n = 1'b1;
        w0 = wr_cnt;
        for (int i = 0; i < 8; i++) begin
            step();
            check("post_rst_we",   32'(dst_we), 32'd0);
            check("post_rst_en",   32'(src_en), 32'd0);
            check("post_rst_done", 32'(done),   32'd0);
        end
        check("post_rst_writes", 32'(wr_cnt - w0), 32'd0);

        // Clean frame after the aborted one
        run_frame(32'd0);
        start = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
